// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the hazard control unit: stall-reason encoding and
// the default register-specifier width.
package cpu_hazard_pkg;

    localparam int DEFAULT_REG_AW = 4;

    typedef enum logic [1:0] {
        RSN_RUN      = 2'd0,
        RSN_LOAD_USE = 2'd1,
        RSN_BRANCH   = 2'd2,
        RSN_FREEZE   = 2'd3
    } stall_reason_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use / branch-operand stalls, memory-busy
// freeze and taken-branch flush, with a registered stall-reason FSM, counters and watchdog.
module hazard_ctrl_unit
    import cpu_hazard_pkg::*;
#(
    parameter int REG_AW          = DEFAULT_REG_AW,
    parameter int ZERO_REG_IGNORE = 1,
    parameter int BR_CHK_MEMWB    = 1,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT         = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_ex_rs,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic              ex_mem_memread,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic              if_id_branch,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              freeze,
    output logic [1:0]        stall_reason,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  frz_cnt,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    function automatic logic reg_match(input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s);
        return (d == s) && ((ZERO_REG_IGNORE == 0) || (d != '0));
    endfunction

    logic          lu_haz, br_haz, br_exmem, br_memwb;
    stall_reason_e state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic          err_q, err_d;

    assign lu_haz   = ex_mem_memread &&
                      (reg_match(ex_mem_rd, id_ex_rs) || reg_match(ex_mem_rd, id_ex_rt));
    assign br_exmem = ex_mem_regwrite &&
                      (reg_match(ex_mem_rd, if_id_rs) || reg_match(ex_mem_rd, if_id_rt));
    assign br_memwb = (BR_CHK_MEMWB != 0) && mem_wb_regwrite &&
                      (reg_match(mem_wb_rd, if_id_rs) || reg_match(mem_wb_rd, if_id_rt));
    assign br_haz   = if_id_branch && (br_exmem || br_memwb);

    // Controls are purely combinational; the taken-branch flush only applies when nothing stalls.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        freeze       = 1'b0;
        state_d      = RSN_RUN;
        if (mem_busy) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            freeze   = 1'b1;
            state_d  = RSN_FREEZE;
        end else if (lu_haz || br_haz) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = lu_haz ? RSN_LOAD_USE : RSN_BRANCH;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    // Watchdog saturates at TIMEOUT so a long freeze cannot wrap it back below the threshold.
    always_comb begin
        wd_d  = '0;
        err_d = err_q;
        if (cnt_clr) begin
            err_d = 1'b0;
        end else if (mem_busy) begin
            wd_d = (wd_q >= TIMEOUT_V) ? TIMEOUT_V : wd_q + CNT_W'(1);
            if (wd_d >= TIMEOUT_V) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RSN_RUN;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (state_d == RSN_LOAD_USE),
        .q   (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (state_d == RSN_BRANCH),
        .q   (br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_frz_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (state_d == RSN_FREEZE),
        .q   (frz_cnt)
    );

    assign stall_reason = state_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized self-checking bench: two differently parameterised instances run
// in lockstep against a behavioural model of the stall/flush/counter rules.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ex_mem_regwrite, ex_mem_memread, mem_wb_regwrite;
    logic       if_id_branch, branch_taken, mem_busy, cnt_clr;
    logic [3:0] id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd, if_id_rs, if_id_rt;

    logic       u0_pc_we, u0_if_id_we, u0_bubble, u0_flush, u0_freeze, u0_err;
    logic [1:0] u0_reason;
    logic [3:0] u0_lu, u0_br, u0_frz;
    logic       u1_pc_we, u1_if_id_we, u1_bubble, u1_flush, u1_freeze, u1_err;
    logic [1:0] u1_reason;
    logic [7:0] u1_lu, u1_br, u1_frz;

    hazard_ctrl_unit #(.REG_AW(4), .ZERO_REG_IGNORE(1), .BR_CHK_MEMWB(1), .CNT_W(4), .TIMEOUT(3)) u0 (
        .clk(clk), .rst(rst), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .if_id_branch(if_id_branch),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .pc_we(u0_pc_we), .if_id_we(u0_if_id_we), .id_ex_bubble(u0_bubble),
        .if_id_flush(u0_flush), .freeze(u0_freeze), .stall_reason(u0_reason),
        .lu_cnt(u0_lu), .br_cnt(u0_br), .frz_cnt(u0_frz), .timeout_err(u0_err));

    hazard_ctrl_unit #(.REG_AW(4), .ZERO_REG_IGNORE(0), .BR_CHK_MEMWB(0), .CNT_W(8), .TIMEOUT(6)) u1 (
        .clk(clk), .rst(rst), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .if_id_branch(if_id_branch),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .pc_we(u1_pc_we), .if_id_we(u1_if_id_we), .id_ex_bubble(u1_bubble),
        .if_id_flush(u1_flush), .freeze(u1_freeze), .stall_reason(u1_reason),
        .lu_cnt(u1_lu), .br_cnt(u1_br), .frz_cnt(u1_frz), .timeout_err(u1_err));

    // Per-instance configuration and model state (index 0 = u0, 1 = u1).
    bit zi_p[2]   = '{1'b1, 1'b0};
    bit bm_p[2]   = '{1'b1, 1'b0};
    int cmax_p[2] = '{15, 255};
    int to_p[2]   = '{3, 6};
    int m_state[2], m_lu[2], m_br[2], m_frz[2], m_wd[2];
    bit m_err[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit hit(input int d, input int s, input bit zi);
        return (d == s) && (!zi || d != 0);
    endfunction

    // 0 run, 1 load-use, 2 branch, 3 freeze, chosen by priority.
    function automatic int reason(input int k);
        bit lu, br;
        lu = ex_mem_memread && (hit(ex_mem_rd, id_ex_rs, zi_p[k]) || hit(ex_mem_rd, id_ex_rt, zi_p[k]));
        br = if_id_branch &&
             ((ex_mem_regwrite && (hit(ex_mem_rd, if_id_rs, zi_p[k]) || hit(ex_mem_rd, if_id_rt, zi_p[k]))) ||
              (bm_p[k] && mem_wb_regwrite && (hit(mem_wb_rd, if_id_rs, zi_p[k]) || hit(mem_wb_rd, if_id_rt, zi_p[k]))));
        if (mem_busy) return 3;
        if (lu) return 1;
        if (br) return 2;
        return 0;
    endfunction

    task automatic check_dut(input int k, input int pc, input int ifw, input int bub, input int fl,
                             input int fz, input int rsn, input int lu, input int br, input int frz,
                             input int err);
        int r;
        r = reason(k);
        check($sformatf("u%0d.pc_we", k), pc, int'(r == 0));
        check($sformatf("u%0d.if_id_we", k), ifw, int'(r == 0));
        check($sformatf("u%0d.id_ex_bubble", k), bub, int'(r == 1 || r == 2));
        check($sformatf("u%0d.if_id_flush", k), fl, int'(r == 0 && branch_taken));
        check($sformatf("u%0d.freeze", k), fz, int'(r == 3));
        check($sformatf("u%0d.stall_reason", k), rsn, m_state[k]);
        check($sformatf("u%0d.lu_cnt", k), lu, m_lu[k]);
        check($sformatf("u%0d.br_cnt", k), br, m_br[k]);
        check($sformatf("u%0d.frz_cnt", k), frz, m_frz[k]);
        check($sformatf("u%0d.timeout_err", k), err, int'(m_err[k]));
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // Called just after the negedge input drive: check, advance model, wait one cycle.
    task automatic step();
        int r;
        #1;
        check_dut(0, u0_pc_we, u0_if_id_we, u0_bubble, u0_flush, u0_freeze, u0_reason,
                  u0_lu, u0_br, u0_frz, u0_err);
        check_dut(1, u1_pc_we, u1_if_id_we, u1_bubble, u1_flush, u1_freeze, u1_reason,
                  u1_lu, u1_br, u1_frz, u1_err);
        $display("t=%0t rst=%0b busy=%0b clr=%0b u0 rsn=%0d lu=%0d br=%0d frz=%0d err=%0b | u1 rsn=%0d lu=%0d br=%0d frz=%0d err=%0b",
                 $time, rst, mem_busy, cnt_clr, u0_reason, u0_lu, u0_br, u0_frz, u0_err,
                 u1_reason, u1_lu, u1_br, u1_frz, u1_err);
        for (int k = 0; k < 2; k++) begin
            r = reason(k);
            if (rst) begin
                m_state[k] = 0; m_lu[k] = 0; m_br[k] = 0; m_frz[k] = 0; m_wd[k] = 0; m_err[k] = 0;
            end else begin
                m_state[k] = r;
                if (cnt_clr) begin
                    m_lu[k] = 0; m_br[k] = 0; m_frz[k] = 0; m_wd[k] = 0; m_err[k] = 0;
                end else begin
                    if (r == 1) m_lu[k]  = sat_inc(m_lu[k], cmax_p[k]);
                    if (r == 2) m_br[k]  = sat_inc(m_br[k], cmax_p[k]);
                    if (r == 3) m_frz[k] = sat_inc(m_frz[k], cmax_p[k]);
                    if (mem_busy) begin
                        m_wd[k] = m_wd[k] + 1;
                        if (m_wd[k] >= to_p[k]) m_err[k] = 1'b1;
                    end else begin
                        m_wd[k] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; ex_mem_regwrite = 0; ex_mem_memread = 0; mem_wb_regwrite = 0;
        if_id_branch = 0; branch_taken = 0; mem_busy = 0; cnt_clr = 0;
        id_ex_rs = 4'd1; id_ex_rt = 4'd2; ex_mem_rd = 4'd7; mem_wb_rd = 4'd8;
        if_id_rs = 4'd9; if_id_rt = 4'd10;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_lu[k] = 0; m_br[k] = 0; m_frz[k] = 0; m_wd[k] = 0; m_err[k] = 0;
        end
        idle(); rst = 1;
        @(posedge clk);
        @(negedge clk);
        step();                                              // reset state
        idle(); ex_mem_memread = 1; ex_mem_rd = 4'd5; id_ex_rt = 4'd5;
        step();                                              // load-use
        idle(); step();
        idle(); ex_mem_memread = 1; ex_mem_rd = 4'd0; id_ex_rs = 4'd0;
        step();                                              // register 0
        idle(); if_id_branch = 1; mem_wb_regwrite = 1; mem_wb_rd = 4'd3; if_id_rs = 4'd3;
        step();                                              // branch vs MEM/WB
        idle(); mem_busy = 1; ex_mem_memread = 1; ex_mem_rd = 4'd5; id_ex_rs = 4'd5; branch_taken = 1;
        step();                                              // freeze priority
        idle(); branch_taken = 1;
        step();                                              // flush
        idle(); step();
        for (int i = 0; i < 20; i++) begin
            idle(); mem_busy = 1; step();                    // saturation and watchdog
        end
        idle(); cnt_clr = 1; step();
        idle(); step();
        for (int i = 0; i < 3; i++) begin
            idle(); mem_busy = 1; step();
        end
        idle(); mem_busy = 1; rst = 1; step();               // reset mid-freeze
        idle(); step();

        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            cnt_clr         = ($urandom_range(0, 39) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0) || (mem_busy && $urandom_range(0, 4) != 0);
            ex_mem_regwrite = 1'($urandom);
            ex_mem_memread  = 1'($urandom);
            mem_wb_regwrite = 1'($urandom);
            if_id_branch    = 1'($urandom);
            branch_taken    = 1'($urandom);
            id_ex_rs  = 4'($urandom_range(0, 3));
            id_ex_rt  = 4'($urandom_range(0, 3));
            ex_mem_rd = 4'($urandom_range(0, 3));
            mem_wb_rd = 4'($urandom_range(0, 3));
            if_id_rs  = 4'($urandom_range(0, 3));
            if_id_rt  = 4'($urandom_range(0, 3));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
